uart_rx_fifo: RTL

Receive-side buffer that sits directly downstream of the uart core. It captures each received byte that the uart strobes out and stores it in a circular FIFO. The single-cycle RISC-V core drains the FIFO through the same we/reg_num/wd register-port style the uart uses, plus a read-enable and a combinational read bus. Status flags, sticky error bits and a threshold interrupt are included.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/fifo_mem.sv | 23 ++
 rtl/uart_rx_fifo.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared register map and bit positions for the uart receive-side blocks.
// Widths that depend on the FIFO size stay in the modules that own them.
package uart_pkg;

   localparam logic [2:0] REG_DATA   = 3'd0;
   localparam logic [2:0] REG_STATUS = 3'd1;
   localparam logic [2:0] REG_CTRL   = 3'd2;

   localparam int ST_EMPTY     = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_OVF       = 2;
   localparam int ST_FERR      = 3;
   localparam int ST_COUNT_LSB = 8;

   localparam int CTRL_FLUSH      = 0;
   localparam int CTRL_IRQ_EN     = 1;
   localparam int CTRL_OVF_IRQ_EN = 2;
   localparam int CTRL_THR_LSB    = 8;

   localparam int THRESH_RST = 1;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage for the receive FIFO: one synchronous write port
// and one asynchronous read port so the head byte is visible without latency.
module fifo_mem #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the uart: captures strobed bytes into a circular FIFO
// and exposes DATA/STATUS/CTRL registers plus a threshold/overflow interrupt.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   input  logic        frame_err_in,
   input  logic        we,
   input  logic        re,
   input  logic [2:0]  reg_num,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        irq
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] THR_RST = (ADDR_W+1)'(THRESH_RST);

   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   count, count_next;
   logic [ADDR_W:0]   threshold, thr_next, thr_wr;
   logic              ovf, ovf_next, ferr, ferr_next;
   logic              irq_en, irq_en_next, ovf_irq_en, ovf_irq_en_next, irq_next;
   logic              empty, full, push_req, push, pop, flush, ovf_set, ferr_set;
   logic              st_wr, ctrl_wr;
   logic [7:0]        head_byte;
   logic              unused_wd;

   assign unused_wd = ^{wd[31:CTRL_THR_LSB+ADDR_W+1], wd[7:4]};

   // Flush outranks both push and pop; a full FIFO still accepts a push when a
   // pop frees a slot in the same cycle, and only a truly dropped byte is an overflow.
   always_comb begin
      empty    = (count == '0);
      full     = (count == DEPTH_C);
      ctrl_wr  = we && (reg_num == REG_CTRL);
      st_wr    = we && (reg_num == REG_STATUS);
      flush    = ctrl_wr && wd[CTRL_FLUSH];
      push_req = byte_valid && !frame_err_in;
      pop      = re && (reg_num == REG_DATA) && !empty && !flush;
      push     = push_req && (!full || pop) && !flush;
      ovf_set  = push_req && full && !pop && !flush;
      ferr_set = byte_valid && frame_err_in;

      count_next = count;
      if (flush)           count_next = '0;
      else if (push && !pop) count_next = count + (ADDR_W+1)'(1);
      else if (pop && !push) count_next = count - (ADDR_W+1)'(1);

      ovf_next  = ovf_set  || (ovf  && !(st_wr && wd[ST_OVF]));
      ferr_next = ferr_set || (ferr && !(st_wr && wd[ST_FERR]));

      thr_wr          = wd[CTRL_THR_LSB +: ADDR_W+1];
      irq_en_next     = ctrl_wr ? wd[CTRL_IRQ_EN]     : irq_en;
      ovf_irq_en_next = ctrl_wr ? wd[CTRL_OVF_IRQ_EN] : ovf_irq_en;
      thr_next        = threshold;
      if (ctrl_wr) thr_next = (thr_wr == '0) ? THR_RST : thr_wr;

      irq_next = (irq_en_next && (count_next >= thr_next)) ||
                 (ovf_irq_en_next && ovf_next);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         ovf        <= 1'b0;
         ferr       <= 1'b0;
         irq_en     <= 1'b0;
         ovf_irq_en <= 1'b0;
         threshold  <= THR_RST;
         irq        <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
         end
         count      <= count_next;
         ovf        <= ovf_next;
         ferr       <= ferr_next;
         irq_en     <= irq_en_next;
         ovf_irq_en <= ovf_irq_en_next;
         threshold  <= thr_next;
         irq        <= irq_next;
      end
   end

   fifo_mem #(.ADDR_W(ADDR_W), .DATA_W(8)) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (byte_in),
      .raddr (rd_ptr),
      .rdata (head_byte)
   );

   // Read bus is purely combinational so the core can read and pop in one cycle.
   always_comb begin
      rd = '0;
      case (reg_num)
         REG_DATA: begin
            if (!empty) begin
               rd[7:0] = head_byte;
               rd[8]   = 1'b1;
            end
         end
         REG_STATUS: begin
            rd[ST_EMPTY]                     = empty;
            rd[ST_FULL]                      = full;
            rd[ST_OVF]                       = ovf;
            rd[ST_FERR]                      = ferr;
            rd[ST_COUNT_LSB +: ADDR_W+1]     = count;
         end
         REG_CTRL: begin
            rd[CTRL_IRQ_EN]                  = irq_en;
            rd[CTRL_OVF_IRQ_EN]              = ovf_irq_en;
            rd[CTRL_THR_LSB +: ADDR_W+1]     = threshold;
         end
         default: rd = '0;
      endcase
   end

endmodule
